// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one spimemio read port among NREQ requesters,
// with config-register writes slotted in only while no read is in flight.
module spi_flash_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [31:0]       req_rdata_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  input  logic              cfg_req_i,
  input  logic [3:0]        cfg_we_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic              cfg_ack_o,
  output logic              mem_valid_o,
  output logic [AW-1:0]     mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [3:0]        mem_cfgreg_we_o,
  output logic [31:0]       mem_cfgreg_di_o
);

  // state | meaning
  // IDLE  | nothing in flight; config write or read grant decided here
  // READ  | mem_valid held until spimemio ready
  // RESP  | req_ready pulse to the owner; no new grant this cycle
  // CFG   | one-cycle cfgreg write with cfg_ack pulse
  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP, S_CFG} state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              mvalid_q, mvalid_d;
  logic [AW-1:0]     maddr_q, maddr_d;
  logic              ack_q, ack_d;
  logic [3:0]        cwe_q, cwe_d;
  logic [31:0]       cdi_q, cdi_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    ready_d  = '0;
    rdata_d  = rdata_q;
    mvalid_d = mvalid_q;
    maddr_d  = maddr_q;
    ack_d    = 1'b0;
    cwe_d    = 4'h0;
    cdi_d    = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (cfg_req_i) begin
          state_d = S_CFG;
          ack_d   = 1'b1;
          cwe_d   = cfg_we_i;
          cdi_d   = cfg_wdata_i;
        end else if (win_found) begin
          state_d  = S_READ;
          ptr_d    = win_idx;
          grant_d  = NREQ'(1) << win_idx;
          mvalid_d = 1'b1;
          maddr_d  = req_addr_i[int'(win_idx)*AW +: AW];
        end
      end
      S_READ: begin
        if (mem_ready_i) begin
          state_d  = S_RESP;
          mvalid_d = 1'b0;
          rdata_d  = mem_rdata_i;
          ready_d  = grant_q;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_CFG:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= PW'(NREQ - 1);
      grant_q  <= '0;
      ready_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      mvalid_q <= 1'b0;
      maddr_q  <= '0;
      ack_q    <= 1'b0;
      cwe_q    <= 4'h0;
      cdi_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      mvalid_q <= mvalid_d;
      maddr_q  <= maddr_d;
      ack_q    <= ack_d;
      cwe_q    <= cwe_d;
      cdi_q    <= cdi_d;
    end
  end

  assign req_ready_o     = ready_q;
  assign req_rdata_o     = rdata_q;
  assign grant_o         = grant_q;
  assign busy_o          = busy_q;
  assign cfg_ack_o       = ack_q;
  assign mem_valid_o     = mvalid_q;
  assign mem_addr_o      = maddr_q;
  assign mem_cfgreg_we_o = cwe_q;
  assign mem_cfgreg_di_o = cdi_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: outputs sampled on the falling edge,
// inputs changed right after sampling, spimemio ready driven by hand.
module tb_spi_flash_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 24;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [31:0]       req_rdata_o;
  logic [NREQ-1:0]   grant_o;
  logic              busy_o;
  logic              cfg_req_i;
  logic [3:0]        cfg_we_i;
  logic [31:0]       cfg_wdata_i;
  logic              cfg_ack_o;
  logic              mem_valid_o;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_ready_i;
  logic [31:0]       mem_rdata_i;
  logic [3:0]        mem_cfgreg_we_o;
  logic [31:0]       mem_cfgreg_di_o;

  int n_vec = 0;
  int n_err = 0;
  int served0, served1;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .req_rdata_o(req_rdata_o),
    .grant_o(grant_o), .busy_o(busy_o),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_ack_o(cfg_ack_o),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .mem_cfgreg_we_o(mem_cfgreg_we_o), .mem_cfgreg_di_o(mem_cfgreg_di_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From a READ cycle: hold off lat-1 cycles, then present ready with data.
  // Returns at the falling edge of the RESP cycle.
  task automatic serve(input int lat, input logic [31:0] data);
    tick(lat - 1);
    mem_ready_i = 1'b1;
    mem_rdata_i = data;
    tick();
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0;
    cfg_req_i = 1'b0; cfg_we_i = 4'h0; cfg_wdata_i = 32'h0;
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    tick(3);
    rst_i = 1'b0;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_mvalid", 32'(mem_valid_o), 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_ack", 32'(cfg_ack_o), 32'h0);
    chk("rst_cfgwe", 32'(mem_cfgreg_we_o), 32'h0);

    // single read from req0, 20-cycle flash latency
    req_addr_i = {24'h000200, 24'h000100};
    req_valid_i = 2'b01;
    tick();
    chk("t1_mvalid", 32'(mem_valid_o), 32'h1);
    chk("t1_maddr", 32'(mem_addr_o), 32'h000100);
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_busy", 32'(busy_o), 32'h1);
    tick(10);
    chk("t1_hold_valid", 32'(mem_valid_o), 32'h1);
    chk("t1_hold_addr", 32'(mem_addr_o), 32'h000100);
    chk("t1_no_early_ready", 32'(req_ready_o), 32'h0);
    serve(10, 32'hDEADBEEF);
    chk("t1_ready", 32'(req_ready_o), 32'h1);
    chk("t1_rdata", req_rdata_o, 32'hDEADBEEF);
    chk("t1_mvalid_drop", 32'(mem_valid_o), 32'h0);
    req_valid_i = 2'b00;
    tick();
    chk("t1_busy_end", 32'(busy_o), 32'h0);
    chk("t1_ready_end", 32'(req_ready_o), 32'h0);

    // both held: strict alternation starting from req0 after reset
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    req_addr_i = {24'h000020, 24'h000010};
    req_valid_i = 2'b11;
    served0 = 0; served1 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_grant", 32'(grant_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t2_maddr", 32'(mem_addr_o), (k % 2 == 0) ? 32'h10 : 32'h20);
      serve(2, 32'h1000 + k);
      chk("t2_ready", 32'(req_ready_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t2_rdata", req_rdata_o, 32'h1000 + k);
      if (req_ready_o == 2'b01) served0++;
      if (req_ready_o == 2'b10) served1++;
      tick();
      chk("t2_idle_gap", 32'(busy_o), 32'h0);
    end
    chk("t2_served0", 32'(served0), 32'd4);
    chk("t2_served1", 32'(served1), 32'd4);
    req_valid_i = 2'b00;
    tick();

    // config write arrives mid-READ; waits, then beats pending req1
    req_valid_i = 2'b01;
    tick();
    chk("t3_grant0", 32'(grant_o), 32'h1);
    cfg_req_i = 1'b1; cfg_we_i = 4'hF; cfg_wdata_i = 32'h80000000;
    req_valid_i = 2'b11;
    tick(3);
    chk("t3_no_we_read", 32'(mem_cfgreg_we_o), 32'h0);
    chk("t3_no_ack_read", 32'(cfg_ack_o), 32'h0);
    serve(2, 32'h5A5A5A5A);
    chk("t3_ready0", 32'(req_ready_o), 32'h1);
    chk("t3_no_we_resp", 32'(mem_cfgreg_we_o), 32'h0);
    req_valid_i = 2'b10;
    tick();
    chk("t3_idle_we", 32'(mem_cfgreg_we_o), 32'h0);
    tick();
    chk("t3_ack", 32'(cfg_ack_o), 32'h1);
    chk("t3_we", 32'(mem_cfgreg_we_o), 32'hF);
    chk("t3_di", mem_cfgreg_di_o, 32'h80000000);
    chk("t3_mvalid_cfg", 32'(mem_valid_o), 32'h0);
    chk("t3_ready_cfg", 32'(req_ready_o), 32'h0);
    cfg_req_i = 1'b0; cfg_we_i = 4'h0; cfg_wdata_i = 32'h0;
    tick();
    chk("t3_we_clear", 32'(mem_cfgreg_we_o), 32'h0);
    chk("t3_ack_clear", 32'(cfg_ack_o), 32'h0);
    chk("t3_mvalid_idle", 32'(mem_valid_o), 32'h0);
    tick();
    chk("t3_grant1", 32'(grant_o), 32'h2);
    chk("t3_maddr1", 32'(mem_addr_o), 32'h20);
    serve(1, 32'h0);
    req_valid_i = 2'b00;
    tick(2);

    // req1 withdraws mid-READ; still completes, no second grant
    req_valid_i = 2'b10;
    tick();
    chk("t5_grant", 32'(grant_o), 32'h2);
    req_valid_i = 2'b00;
    serve(3, 32'hCAFEF00D);
    chk("t5_ready", 32'(req_ready_o), 32'h2);
    chk("t5_rdata", req_rdata_o, 32'hCAFEF00D);
    tick(2);
    chk("t5_no_regrant", 32'(mem_valid_o), 32'h0);
    chk("t5_busy", 32'(busy_o), 32'h0);

    // reset mid-READ, late ready ignored, pointer back to req0
    req_valid_i = 2'b10;
    tick(2);
    chk("t4_in_read", 32'(mem_valid_o), 32'h1);
    rst_i = 1'b1; req_valid_i = 2'b00;
    tick();
    rst_i = 1'b0;
    chk("t4_mvalid", 32'(mem_valid_o), 32'h0);
    chk("t4_grant", 32'(grant_o), 32'h0);
    chk("t4_busy", 32'(busy_o), 32'h0);
    chk("t4_maddr", 32'(mem_addr_o), 32'h0);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    chk("t4_late_ready", 32'(req_ready_o), 32'h0);
    chk("t4_late_busy", 32'(busy_o), 32'h0);
    req_valid_i = 2'b11;
    tick();
    chk("t4_regrant0", 32'(grant_o), 32'h1);
    serve(1, 32'h0);
    req_valid_i = 2'b00;
    tick(2);

    // stray ready while idle
    mem_ready_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    chk("t6_ready", 32'(req_ready_o), 32'h0);
    chk("t6_busy", 32'(busy_o), 32'h0);
    tick();
    chk("t6_busy2", 32'(busy_o), 32'h0);
    chk("t6_mvalid", 32'(mem_valid_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
